// File: rtl/expr_misr_pkg.sv
// Shared types, default widths/constants and the result-folding helper for
// the expression response MISR capture stage.
package expr_misr_pkg;

    // Run control states of the capture stage
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default widths of the result bus, signature and vector counter
    localparam int EXPR_Y_W   = 90;
    localparam int EXPR_SIG_W = 32;
    localparam int EXPR_CNT_W = 16;

    // Result bus zero-padded up to a whole number of signature words
    localparam int EXPR_FOLD_W = 96;

    // Default MISR feedback polynomial and starting signature
    localparam logic [EXPR_SIG_W-1:0] EXPR_POLY = 32'h04C11DB7;
    localparam logic [EXPR_SIG_W-1:0] EXPR_SEED = 32'h00000000;

    // Compress one result into a signature-wide word: pad with zeros, then
    // XOR the three 32-bit slices together.
    function automatic logic [EXPR_SIG_W-1:0] fold(input logic [EXPR_Y_W-1:0] y);
        logic [EXPR_FOLD_W-1:0] padded;
        padded = {{(EXPR_FOLD_W-EXPR_Y_W){1'b0}}, y};
        return padded[31:0] ^ padded[63:32] ^ padded[95:64];
    endfunction

endpackage

// File: rtl/expr_misr_step.sv
// Combinational MISR update: shifts the signature left, applies polynomial
// feedback when the outgoing bit is set, and mixes in the folded result.
module expr_misr_step
    import expr_misr_pkg::*;
#(
    parameter logic [EXPR_SIG_W-1:0] POLY = EXPR_POLY
) (
    input  logic [EXPR_SIG_W-1:0] sig,
    input  logic [EXPR_Y_W-1:0]   y,
    output logic [EXPR_SIG_W-1:0] sig_next
);

    logic [EXPR_SIG_W-1:0] feedback;

    // Next signature from the current one and the result being absorbed
    always_comb begin
        feedback = sig[EXPR_SIG_W-1] ? POLY : '0;
        sig_next = {sig[EXPR_SIG_W-2:0], 1'b0} ^ feedback ^ fold(y);
    end

endmodule

// File: rtl/expr_response_misr.sv
// Capture stage for the generated expression DUTs: absorbs a programmed number
// of results over valid/ready and compresses them into one MISR signature.
// Optional compare port set enabled by defining EXPR_MISR_CMP_EN.
module expr_response_misr
    import expr_misr_pkg::*;
#(
    parameter int                    CNT_W = EXPR_CNT_W,
    parameter logic [EXPR_SIG_W-1:0] POLY  = EXPR_POLY,
    parameter logic [EXPR_SIG_W-1:0] SEED  = EXPR_SEED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_vectors,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXPR_Y_W-1:0]   in_y,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      count,
`ifdef EXPR_MISR_CMP_EN
    input  logic [EXPR_SIG_W-1:0] expected_sig,
    output logic                  pass,
`endif
    output logic [EXPR_SIG_W-1:0] signature
);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        target_q, target_d;
    logic [EXPR_SIG_W-1:0]   sig_q, sig_d;
    logic [EXPR_SIG_W-1:0]   sig_step;
    logic                    accept;
`ifdef EXPR_MISR_CMP_EN
    logic [EXPR_SIG_W-1:0]   expected_q, expected_d;
`endif

    expr_misr_step #(
        .POLY     (POLY)
    ) u_step (
        .sig      (sig_q),
        .y        (in_y),
        .sig_next (sig_step)
    );

    // in_ready only depends on state, so accept has no combinational path
    // back from in_valid to in_ready.
    assign accept = in_valid & in_ready;

    // State register; reset abandons any run in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            target_q   <= '0;
            sig_q      <= SEED;
`ifdef EXPR_MISR_CMP_EN
            expected_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            target_q   <= target_d;
            sig_q      <= sig_d;
`ifdef EXPR_MISR_CMP_EN
            expected_q <= expected_d;
`endif
        end
    end

    // Next-state and datapath update: start only counts outside RUN, and
    // the accept of the final vector moves straight to DONE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        target_d   = target_q;
        sig_d      = sig_q;
`ifdef EXPR_MISR_CMP_EN
        expected_d = expected_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d      = SEED;
                    count_d    = '0;
                    target_d   = num_vectors;
`ifdef EXPR_MISR_CMP_EN
                    expected_d = expected_sig;
`endif
                    state_d    = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d   = sig_step;
                    count_d = count_q + CNT_W'(1);
                    if (count_d == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the registered state
    always_comb begin
        in_ready  = (state_q == RUN);
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        count     = count_q;
        signature = sig_q;
`ifdef EXPR_MISR_CMP_EN
        pass      = (state_q == DONE) && (sig_q == expected_q);
`endif
    end

endmodule

// File: tb/tb_expr_response_misr.sv
// Randomised scoreboard bench for expr_response_misr. The stimulus pushes the
// expected end-of-run result computed by a reference model; an independent
// monitor pops and compares whenever a run completes.
module tb_expr_response_misr;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'h00000000;

    typedef struct packed {
        logic [31:0] sig;
        logic [15:0] cnt;
        logic        pss;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_vectors;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_y;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic [31:0] signature;
`ifdef EXPR_MISR_CMP_EN
    logic [31:0] expected_sig;
    logic        pass;
`endif

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [89:0] vec_y [0:15];
    logic        done_prev;
    logic        acc_pending;

    expr_response_misr dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_vectors  (num_vectors),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_y         (in_y),
        .busy         (busy),
        .done         (done),
        .count        (count),
`ifdef EXPR_MISR_CMP_EN
        .expected_sig (expected_sig),
        .pass         (pass),
`endif
        .signature    (signature)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference signature over vec_y[0..n-1]: each result is split into
    // 32-bit words by shifting, words XORed, then a polynomial-division step.
    function automatic logic [31:0] model_run(input int n);
        logic [31:0] s;
        logic [95:0] w;
        logic [31:0] f;
        logic [32:0] dbl;
        s = SEED;
        for (int k = 0; k < n; k++) begin
            w   = 96'(vec_y[k]);
            f   = 32'(w) ^ 32'(w >> 32) ^ 32'(w >> 64);
            dbl = 33'(s) * 33'd2;
            s   = dbl[31:0] ^ (dbl[32] ? POLY : 32'h0) ^ f;
        end
        return s;
    endfunction

    // One run: push expectation, pulse start, then feed nv results with the
    // chosen valid pattern. abort_after>0 stops feeding after that many accepts.
    task automatic applyStimulus(input int nv, input int valid_mode, input bit start_mid,
                                 input int abort_after, input logic [31:0] exp_cmp);
        exp_t e;
        int   i;
        int   cyc;
        logic acc;
        e.sig = model_run(nv);
        e.cnt = 16'(nv);
        e.pss = (e.sig == exp_cmp);
        if (abort_after == 0) sb_q.push_back(e);
        @(posedge clk); #1;
        start       = 1'b1;
        num_vectors = 16'(nv);
`ifdef EXPR_MISR_CMP_EN
        expected_sig = exp_cmp;
`endif
        @(posedge clk); #1;
        start       = 1'b0;
        num_vectors = 16'd0;
        i   = 0;
        cyc = 0;
        while (i < nv && cyc < 200) begin
            if (abort_after > 0 && i == abort_after) break;
            case (valid_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom % 3) != 0;
            endcase
            in_y  = in_valid ? vec_y[i] : 90'({$urandom(), $urandom(), $urandom()});
            start = start_mid && (cyc == 2);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        if (abort_after == 0) checkOutput("accept_count", 32'(i), 32'(nv));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: a run has completed when done rises, or when done stays high
    // right after a start was taken from DONE (zero-length run).
    initial begin
        exp_t e;
        done_prev   = 1'b0;
        acc_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_prev   = 1'b0;
                acc_pending = 1'b0;
            end else begin
                if (done && (!done_prev || acc_pending)) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("sb_unexpected_done", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("sb_signature", signature, e.sig);
                        checkOutput("sb_count", 32'(count), 32'(e.cnt));
                        checkOutput("sb_ready_low", 32'(in_ready), 32'd0);
                        checkOutput("sb_busy_low", 32'(busy), 32'd0);
`ifdef EXPR_MISR_CMP_EN
                        checkOutput("sb_pass", 32'(pass), 32'(e.pss));
`endif
                    end
                end
                done_prev   = done;
                acc_pending = start && !busy;
            end
        end
    end

    // Watchdog so a stuck run still ends the simulation
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          nv;
        logic [31:0] m;
        reset       = 1'b1;
        start       = 1'b0;
        num_vectors = 16'd0;
        in_valid    = 1'b1;
        in_y        = 90'h0;
`ifdef EXPR_MISR_CMP_EN
        expected_sig = 32'h0;
`endif
        for (int k = 0; k < 16; k++) vec_y[k] = 90'h0;

        $display("[TB] reset with in_valid high");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_signature", signature, 32'h0);
`ifdef EXPR_MISR_CMP_EN
        checkOutput("rst_pass", 32'(pass), 32'd0);
`endif
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;

        $display("[TB] single vector y=1");
        vec_y[0] = 90'h1;
        applyStimulus(1, 0, 1'b0, 0, 32'h1);
        checkOutput("done_held", 32'(done), 32'd1);
        checkOutput("sig_held", signature, 32'h1);

        $display("[TB] two vectors, upper word then zero");
        vec_y[0] = 90'h1 << 64;
        vec_y[1] = 90'h0;
        applyStimulus(2, 0, 1'b0, 0, 32'h0);

        $display("[TB] cancelling fold and zero-length run");
        vec_y[0] = (90'h1 << 32) | 90'h1;
        applyStimulus(1, 0, 1'b0, 0, 32'h0);
        applyStimulus(0, 0, 1'b0, 0, 32'h0);

        $display("[TB] toggling valid with start during run");
        for (int k = 0; k < 3; k++) vec_y[k] = 90'({$urandom(), $urandom(), $urandom()});
        applyStimulus(3, 1, 1'b1, 0, model_run(3));

        $display("[TB] reset after one of four accepts");
        for (int k = 0; k < 4; k++) vec_y[k] = 90'({$urandom(), $urandom(), $urandom()}) | 90'h1;
        applyStimulus(4, 0, 1'b0, 1, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(in_ready), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_count", 32'(count), 32'd0);
        checkOutput("abort_signature", signature, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] randomised runs");
        for (int r = 0; r < 8; r++) begin
            nv = int'($urandom_range(1, 12));
            for (int k = 0; k < nv; k++) vec_y[k] = 90'({$urandom(), $urandom(), $urandom()});
            m = model_run(nv);
            applyStimulus(nv, r % 3, r[0], 0, (r % 2 == 0) ? m : (m ^ 32'h1));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
